tohost_monitor: RTL and testbench

TOHOST_MONITOR -- requirements
Module: tohost_monitor

---
 rtl/tohost_pkg.sv | 16 +
 rtl/tohost_decode.sv | 23 ++
 rtl/tohost_monitor.sv | 163 ++++++++++++++++
 tb/tb_tohost_monitor.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost run monitor: FSM encoding and the
// result-word conventions written by test programs to the tohost address.
package tohost_pkg;

  typedef enum logic [1:0] {
    ST_CORE_RST = 2'd0,
    ST_RUN      = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  // A result word always has bit 0 set; the value 1 alone means pass,
  // otherwise the failing test number sits in the bits above bit 0.
  localparam int unsigned PASS_WORD = 1;
  localparam int unsigned CODE_LSB  = 1;

endpackage

// File: rtl/tohost_decode.sv
// Per-hart tohost store decode: flags a result write and splits it into
// pass/fail and the failing test number.
module tohost_decode
  import tohost_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 16'h1000
) (
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reported,
  output logic              hit,
  output logic              is_pass,
  output logic [DATA_W-2:0] code
);

  assign hit     = wr_en && (wr_addr == TOHOST_ADDR) && wr_data[0] && !reported;
  assign is_pass = (wr_data == DATA_W'(PASS_WORD));
  assign code    = wr_data[DATA_W-1:CODE_LSB];

endmodule

// File: rtl/tohost_monitor.sv
// Run controller: pulses core reset, watches every hart's tohost stores,
// and latches the pass/fail/timeout verdict until restarted.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int unsigned       NUM_HARTS     = 1,
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       DATA_W        = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR   = 16'h1000,
  parameter int unsigned       TIMEOUT_TICKS = 5000,
  parameter int unsigned       RST_CYCLES    = 2,
  localparam int unsigned      HART_W        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           restart,
  input  logic [NUM_HARTS-1:0]           wr_en,
  input  logic [NUM_HARTS*ADDR_W-1:0]    wr_addr,
  input  logic [NUM_HARTS*DATA_W-1:0]    wr_data,
  output logic                           core_rst,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [HART_W-1:0]              fail_hart,
  output logic [DATA_W-2:0]              fail_code,
  output logic [31:0]                    cycles,
  output logic [NUM_HARTS-1:0]           hart_done
);

  localparam int unsigned          RCNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCNT_W-1:0]    RCNT_LAST = RCNT_W'(RST_CYCLES - 1);
  localparam logic [31:0]          TMO_LAST  = 32'(TIMEOUT_TICKS - 1);
  localparam logic [NUM_HARTS-1:0] ALL_HARTS = '1;

  state_e                 state_q, state_d;
  logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
  logic [31:0]            cycles_q, cycles_d, cycles_inc;
  logic [NUM_HARTS-1:0]   hdone_q, hdone_d, hdone_all;
  logic                   pass_q, pass_d, tmo_q, tmo_d;
  logic [HART_W-1:0]      fhart_q, fhart_d, fail_idx;
  logic [DATA_W-2:0]      fcode_q, fcode_d, fail_val;
  logic [NUM_HARTS-1:0]   hit, is_pass;
  logic [DATA_W-2:0]      code [NUM_HARTS];
  logic                   fail_any;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    tohost_decode #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TOHOST_ADDR (TOHOST_ADDR)
    ) u_decode (
      .wr_en    (wr_en[h]),
      .wr_addr  (wr_addr[h*ADDR_W +: ADDR_W]),
      .wr_data  (wr_data[h*DATA_W +: DATA_W]),
      .reported (hdone_q[h]),
      .hit      (hit[h]),
      .is_pass  (is_pass[h]),
      .code     (code[h])
    );
  end

  // Lowest-numbered failing hart wins when several fail in one cycle.
  always_comb begin
    fail_any = 1'b0;
    fail_idx = '0;
    fail_val = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (hit[h] && !is_pass[h] && !fail_any) begin
        fail_any = 1'b1;
        fail_idx = HART_W'(h);
        fail_val = code[h];
      end
    end
  end

  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
  assign hdone_all  = hdone_q | hit;

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    cycles_d = cycles_q;
    hdone_d  = hdone_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    fhart_d  = fhart_q;
    fcode_d  = fcode_q;
    case (state_q)
      ST_CORE_RST: begin
        if (rcnt_q == RCNT_LAST) begin
          state_d  = ST_RUN;
          rcnt_d   = '0;
          cycles_d = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cycles_d = cycles_inc;
        hdone_d  = hdone_all;
        if (fail_any) begin
          state_d = ST_DONE;
          fhart_d = fail_idx;
          fcode_d = fail_val;
          pass_d  = 1'b0;
        end else if (hdone_all == ALL_HARTS) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else if ((hit == '0) && (cycles_q >= TMO_LAST)) begin
          // A pass that leaves the run open past the budget defers the
          // watchdog to the next hit-free cycle.
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end
      ST_DONE: begin
        if (restart) begin
          state_d  = ST_CORE_RST;
          rcnt_d   = '0;
          cycles_d = '0;
          hdone_d  = '0;
          pass_d   = 1'b0;
          tmo_d    = 1'b0;
          fhart_d  = '0;
          fcode_d  = '0;
        end
      end
      default: state_d = ST_CORE_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_CORE_RST;
      rcnt_q   <= '0;
      cycles_q <= '0;
      hdone_q  <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      fhart_q  <= '0;
      fcode_q  <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      cycles_q <= cycles_d;
      hdone_q  <= hdone_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      fhart_q  <= fhart_d;
      fcode_q  <= fcode_d;
    end
  end

  assign core_rst  = (state_q != ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign fail_hart = fhart_q;
  assign fail_code = fcode_q;
  assign cycles    = cycles_q;
  assign hart_done = hdone_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: a 1-hart and a 4-hart instance driven with
// directed and random store schedules, checked through a verdict scoreboard.
module tb_tohost_monitor;

  localparam int          TMO1 = 100;
  localparam int          TMO4 = 200;
  localparam int          RC1  = 2;
  localparam int          RC4  = 3;
  localparam logic [15:0] TH   = 16'h1000;

  typedef struct {
    int          cyc;
    int          hart;
    logic [15:0] addr;
    logic [31:0] data;
  } sched_t;

  typedef struct packed {
    logic        pass;
    logic        tmo;
    logic [1:0]  fh;
    logic [30:0] fc;
    logic [31:0] cyc;
    logic [3:0]  hd;
    logic [3:0]  mask;
  } exp_t;

  typedef struct {
    string       name;
    int          d;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b0, rst4 = 1'b0, restart1 = 1'b0, restart4 = 1'b0;
  int   sel = 0;
  logic [3:0]   bus_en   = '0;
  logic [63:0]  bus_addr = '0;
  logic [127:0] bus_data = '0;
  logic         wr_en1;
  logic [3:0]   wr_en4;
  assign wr_en1 = (sel == 0) ? bus_en[0] : 1'b0;
  assign wr_en4 = (sel == 1) ? bus_en : 4'b0;

  logic        crst1, done1, pass1, tmo1;
  logic [0:0]  fh1;
  logic [30:0] fc1;
  logic [31:0] cyc1;
  logic [0:0]  hd1;
  logic        crst4, done4, pass4, tmo4;
  logic [1:0]  fh4;
  logic [30:0] fc4;
  logic [31:0] cyc4;
  logic [3:0]  hd4;

  tohost_monitor #(
    .NUM_HARTS(1), .ADDR_W(16), .DATA_W(32), .TOHOST_ADDR(16'h1000),
    .TIMEOUT_TICKS(TMO1), .RST_CYCLES(RC1)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .restart(restart1),
    .wr_en(wr_en1), .wr_addr(bus_addr[15:0]), .wr_data(bus_data[31:0]),
    .core_rst(crst1), .done(done1), .pass(pass1), .timeout(tmo1),
    .fail_hart(fh1), .fail_code(fc1), .cycles(cyc1), .hart_done(hd1)
  );

  tohost_monitor #(
    .NUM_HARTS(4), .ADDR_W(16), .DATA_W(32), .TOHOST_ADDR(16'h1000),
    .TIMEOUT_TICKS(TMO4), .RST_CYCLES(RC4)
  ) u_dut4 (
    .clk(clk), .rst(rst4), .restart(restart4),
    .wr_en(wr_en4), .wr_addr(bus_addr), .wr_data(bus_data),
    .core_rst(crst4), .done(done4), .pass(pass4), .timeout(tmo4),
    .fail_hart(fh4), .fail_code(fc4), .cycles(cyc4), .hart_done(hd4)
  );

  logic        done_v [2], pass_v [2], tmo_v [2], crst_v [2];
  logic [1:0]  fh_v   [2];
  logic [30:0] fc_v   [2];
  logic [31:0] cyc_v  [2];
  logic [3:0]  hd_v   [2];
  assign done_v[0] = done1;  assign done_v[1] = done4;
  assign pass_v[0] = pass1;  assign pass_v[1] = pass4;
  assign tmo_v[0]  = tmo1;   assign tmo_v[1]  = tmo4;
  assign crst_v[0] = crst1;  assign crst_v[1] = crst4;
  assign fh_v[0]   = {1'b0, fh1};  assign fh_v[1] = fh4;
  assign fc_v[0]   = fc1;    assign fc_v[1]   = fc4;
  assign cyc_v[0]  = cyc1;   assign cyc_v[1]  = cyc4;
  assign hd_v[0]   = {3'b000, hd1};  assign hd_v[1] = hd4;

  sched_t sched [$];
  exp_t   exp_q0 [$];
  exp_t   exp_q1 [$];
  chk_t   chk_q [$];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic void post(input string n, input int d, input logic [63:0] a, input logic [63:0] e);
    chk_t c;
    c.name = n; c.d = d; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endfunction

  function automatic void chk(input string n, input int d, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", n, d, a, e);
    end
  endfunction

  // Reference verdict from the store schedule: walks RUN cycles, applying the
  // hit / pass / fail / all-reported / watchdog rules in order.
  function automatic exp_t model(input int nh, input int tmo);
    exp_t        e;
    logic [3:0]  rep, hits, fails, all;
    logic [31:0] fdata [4];
    e = '0; e.mask = '1; rep = '0;
    all = 4'((1 << nh) - 1);
    for (int i = 0; i < 4; i++) fdata[i] = '0;
    for (int k = 0; k < 100000; k++) begin
      hits = '0; fails = '0;
      foreach (sched[i]) begin
        int h;
        h = sched[i].hart;
        if (sched[i].cyc == k && h < nh && sched[i].addr == TH && sched[i].data[0] && !rep[h]) begin
          hits[h]  = 1'b1;
          fdata[h] = sched[i].data;
          if (sched[i].data != 32'd1) fails[h] = 1'b1;
        end
      end
      rep   = rep | hits;
      e.cyc = 32'(k + 1);
      e.hd  = rep;
      if (fails != '0) begin
        for (int h = 3; h >= 0; h--) begin
          if (fails[h]) begin
            e.fh = 2'(h);
            e.fc = fdata[h][31:1];
          end
        end
        // other failing harts in the same cycle are not constrained
        e.mask = ~(fails & ~(4'b0001 << e.fh));
        return e;
      end
      if (rep == all) begin e.pass = 1'b1; return e; end
      if (hits == '0 && k + 1 >= tmo) begin e.tmo = 1'b1; return e; end
    end
    return e;
  endfunction

  // Monitor: drains posted checks and compares each rising done against
  // the next expected verdict for that instance.
  exp_t me;
  chk_t mc;
  bit   mhave;
  logic done_prev [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mc = chk_q.pop_front();
      chk(mc.name, mc.d, mc.act, mc.exp);
    end
    for (int d = 0; d < 2; d++) begin
      if (done_v[d] === 1'b1 && done_prev[d] !== 1'b1) begin
        mhave = 1'b0;
        if (d == 0 && exp_q0.size() > 0) begin me = exp_q0.pop_front(); mhave = 1'b1; end
        if (d == 1 && exp_q1.size() > 0) begin me = exp_q1.pop_front(); mhave = 1'b1; end
        if (!mhave) begin
          chk("unexpected_done", d, 64'(done_v[d]), 64'd0);
        end else begin
          chk("pass",      d, 64'(pass_v[d]), 64'(me.pass));
          chk("timeout",   d, 64'(tmo_v[d]),  64'(me.tmo));
          chk("fail_hart", d, 64'(fh_v[d]),   64'(me.fh));
          chk("fail_code", d, 64'(fc_v[d]),   64'(me.fc));
          chk("cycles",    d, 64'(cyc_v[d]),  64'(me.cyc));
          chk("hart_done", d, 64'(hd_v[d] & me.mask), 64'(me.hd & me.mask));
          chk("done_core_rst", d, 64'(crst_v[d]), 64'd1);
        end
      end
      done_prev[d] = done_v[d];
    end
  end

  task automatic set_rst(input int d, input logic v);
    if (d == 0) rst1 = v; else rst4 = v;
  endtask

  task automatic set_restart(input int d, input logic v);
    if (d == 0) restart1 = v; else restart4 = v;
  endtask

  task automatic post_cleared(input string tag, input int d);
    post({tag, "_done"},      d, 64'(done_v[d]), 64'd0);
    post({tag, "_pass"},      d, 64'(pass_v[d]), 64'd0);
    post({tag, "_timeout"},   d, 64'(tmo_v[d]),  64'd0);
    post({tag, "_fail_hart"}, d, 64'(fh_v[d]),   64'd0);
    post({tag, "_fail_code"}, d, 64'(fc_v[d]),   64'd0);
    post({tag, "_cycles"},    d, 64'(cyc_v[d]),  64'd0);
    post({tag, "_hart_done"}, d, 64'(hd_v[d]),   64'd0);
  endtask

  task automatic drive(input int k);
    bus_en = '0; bus_addr = '0; bus_data = '0;
    foreach (sched[i]) begin
      if (sched[i].cyc == k) begin
        bus_en[sched[i].hart]              = 1'b1;
        bus_addr[sched[i].hart*16 +: 16]   = sched[i].addr;
        bus_data[sched[i].hart*32 +: 32]   = sched[i].data;
      end
    end
  endtask

  task automatic add(input int c, input int h, input logic [15:0] a, input logic [31:0] v);
    sched_t s;
    s.cyc = c; s.hart = h; s.addr = a; s.data = v;
    sched.push_back(s);
  endtask

  task automatic gen_random(input int nh);
    sched.delete();
    for (int h = 0; h < nh; h++) begin
      int n, c;
      n = $urandom_range(0, 3);
      c = $urandom_range(0, 60);
      for (int j = 0; j < n; j++) begin
        int          r;
        logic [31:0] v;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        a = TH; v = 32'd1;
        if (r < 20) begin
          v = $urandom() | 32'h1;
          if (v == 32'd1) v = 32'd3;
        end else if (r < 35) begin
          v = $urandom() & ~32'h1;
        end else if (r < 50) begin
          a = TH ^ 16'($urandom_range(1, 65535));
        end
        add(c, h, a, v);
        c += $urandom_range(1, 80);
      end
    end
  endtask

  // One run: start via reset release or restart, check core reset length and
  // cleared outputs, then play the schedule until done (or abort at abort_k).
  task automatic do_run(input int d, input bit use_reset, input int abort_k);
    int rc, cnt, k;
    bit seen;
    rc  = (d == 0) ? RC1 : RC4;
    sel = d;
    bus_en = '0;
    if (abort_k < 0) begin
      if (d == 0) exp_q0.push_back(model(1, TMO1));
      else        exp_q1.push_back(model(4, TMO4));
    end
    if (use_reset) begin
      @(negedge clk);
      set_rst(d, 1'b0);
      repeat (2) @(negedge clk);
      post_cleared("reset", d);
      post("reset_core_rst", d, 64'(crst_v[d]), 64'd1);
      set_rst(d, 1'b1);
      #1;
    end else begin
      set_restart(d, 1'b1);
      @(negedge clk);
      set_restart(d, 1'b0);
    end
    cnt = 0;
    while (crst_v[d] === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    post("core_rst_len", d, 64'(cnt), 64'(rc));
    post_cleared("run_start", d);
    k = 0; seen = 1'b0;
    while (!seen && k < 1000) begin
      if (k == abort_k) begin
        #2;
        set_rst(d, 1'b0);
        #1;
        post_cleared("abort", d);
        post("abort_core_rst", d, 64'(crst_v[d]), 64'd1);
        bus_en = '0;
        return;
      end
      drive(k);
      @(negedge clk);
      seen = (done_v[d] === 1'b1);
      k++;
    end
    bus_en = '0;
    post("run_finished", d, 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    post("scoreboard_drained", d, 64'((d == 0) ? exp_q0.size() : exp_q1.size()), 64'd0);
  endtask

  initial begin
    // single hart, directed
    sched.delete();
    add(10, 0, TH, 32'd6);
    add(20, 0, 16'h1004, 32'd1);
    add(40, 0, TH, 32'd1);
    do_run(0, 1'b1, -1);
    sched.delete(); add(15, 0, TH, 32'h7);  do_run(0, 1'b0, -1);
    sched.delete();                         do_run(0, 1'b0, -1);
    sched.delete(); add(99, 0, TH, 32'd1);  do_run(0, 1'b0, -1);
    sched.delete(); add(98, 0, TH, 32'd8);  do_run(0, 1'b0, -1);
    sched.delete();                         do_run(0, 1'b0, 30);
    do_run(0, 1'b1, -1);
    sched.delete(); add(5, 0, TH, 32'd1);   do_run(0, 1'b0, -1);
    repeat (6) begin gen_random(1); do_run(0, 1'b0, -1); end

    // four harts, directed
    sched.delete();
    add(12, 2, TH, 32'd5);
    add(12, 1, TH, 32'd9);
    do_run(1, 1'b1, -1);
    sched.delete();
    add(10, 0, TH, 32'd1);
    add(20, 1, TH, 32'd1);
    add(20, 2, TH, 32'd1);
    add(25, 0, TH, 32'h5);
    add(30, 3, TH, 32'd1);
    do_run(1, 1'b0, -1);
    sched.delete();
    add(8, 1, TH, 32'd3);
    add(8, 3, TH, 32'd1);
    add(8, 2, TH, 32'd5);
    do_run(1, 1'b0, -1);
    sched.delete();
    add(199, 1, TH, 32'd1);
    add(205, 2, TH, 32'd1);
    do_run(1, 1'b0, -1);
    repeat (12) begin gen_random(4); do_run(1, 1'b0, -1); end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
